// File: rtl/systolic_result_collector.sv
// Reassembles the serialized systolic result stream into tagged N-element rows, buffered in a row FIFO.
// Optional SYSTOLIC_COLLECT_ROWSUM_EN adds a per-row sign-extended sum output (row_sum).
module systolic_result_collector #(
    parameter int DIN_WIDTH = 8,
    parameter int N         = 4,
    parameter int DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             out_valid,
    input  logic [2*DIN_WIDTH-1:0]           c_dout,
    input  logic [$clog2(N)-1:0]             c_dout_idx,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic [N*2*DIN_WIDTH-1:0]         row_data,
    output logic [$clog2(N)-1:0]             row_tag,
    output logic [$clog2(DEPTH):0]           fifo_level,
    output logic                             seq_err,
    output logic                             ovf_err,
`ifdef SYSTOLIC_COLLECT_ROWSUM_EN
    output logic [2*DIN_WIDTH+$clog2(N)-1:0] row_sum,
`endif
    input  logic                             err_clr
);
    localparam int W  = 2 * DIN_WIDTH;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {COLLECT, RESYNC} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        exp_idx_q, exp_idx_d;
    logic [IW-1:0]        tag_cnt_q, tag_cnt_d;
    logic [N-1:0][W-1:0]  buf_q, buf_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 seq_err_q, seq_err_d, ovf_err_q, ovf_err_d;

    logic [N*W-1:0]       data_mem [DEPTH];
    logic [IW-1:0]        tag_mem  [DEPTH];

    logic                 push, pop, full, do_push, seq_evt, ovf_evt;
    logic                 word_store, row_restart, row_drop;
    logic [N*W-1:0]       push_row;

    always_comb begin
        state_d     = state_q;
        exp_idx_d   = exp_idx_q;
        tag_cnt_d   = tag_cnt_q;
        buf_d       = buf_q;
        push        = 1'b0;
        push_row    = '0;
        seq_evt     = 1'b0;
        word_store  = 1'b0;
        row_restart = 1'b0;
        row_drop    = 1'b0;
        if (out_valid) begin
            case (state_q)
                COLLECT: begin
                    if (c_dout_idx == exp_idx_q) begin
                        word_store       = 1'b1;
                        buf_d[exp_idx_q] = c_dout;
                        if (exp_idx_q == IW'(N - 1)) begin
                            push      = 1'b1;
                            push_row  = buf_d;
                            buf_d     = '0;
                            exp_idx_d = '0;
                            tag_cnt_d = (tag_cnt_q == IW'(N - 1)) ? '0 : tag_cnt_q + 1'b1;
                        end else begin
                            exp_idx_d = exp_idx_q + 1'b1;
                        end
                    end else begin
                        // Out-of-order word: the partial row is lost; an idx 0 word restarts immediately.
                        seq_evt = 1'b1;
                        buf_d   = '0;
                        if (c_dout_idx == '0) begin
                            row_restart = 1'b1;
                            buf_d[0]    = c_dout;
                            exp_idx_d   = IW'(1);
                        end else begin
                            row_drop  = 1'b1;
                            exp_idx_d = '0;
                            state_d   = RESYNC;
                        end
                    end
                end
                RESYNC: begin
                    if (c_dout_idx == '0) begin
                        row_restart = 1'b1;
                        buf_d       = '0;
                        buf_d[0]    = c_dout;
                        exp_idx_d   = IW'(1);
                        state_d     = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    // Row FIFO; a pop frees a slot for a completing row in the same cycle even when full.
    always_comb begin
        row_valid = (level_q != '0);
        pop       = row_valid && row_ready;
        full      = (level_q == LW'(DEPTH));
        do_push   = push && (!full || pop);
        ovf_evt   = push && full && !pop;
        wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d   = level_q + LW'(do_push) - LW'(pop);
        seq_err_d = (seq_err_q && !err_clr) || seq_evt;
        ovf_err_d = (ovf_err_q && !err_clr) || ovf_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= COLLECT;
            exp_idx_q <= '0;
            tag_cnt_q <= '0;
            buf_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            seq_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_idx_q <= exp_idx_d;
            tag_cnt_q <= tag_cnt_d;
            buf_q     <= buf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            seq_err_q <= seq_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr_q] <= push_row;
            tag_mem[wr_ptr_q]  <= tag_cnt_q;
        end
    end

    assign row_data   = row_valid ? data_mem[rd_ptr_q] : '0;
    assign row_tag    = row_valid ? tag_mem[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign seq_err    = seq_err_q;
    assign ovf_err    = ovf_err_q;

`ifdef SYSTOLIC_COLLECT_ROWSUM_EN
    localparam int SW = W + IW;

    logic [SW-1:0] sum_q, sum_d, word_ext, push_sum;
    logic [SW-1:0] sum_mem [DEPTH];

    always_comb begin
        word_ext = {{IW{c_dout[W-1]}}, c_dout};
        push_sum = sum_q + word_ext;
        sum_d    = sum_q;
        if (push || row_drop)
            sum_d = '0;
        else if (row_restart)
            sum_d = word_ext;
        else if (word_store)
            sum_d = sum_q + word_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    always_ff @(posedge clk) begin
        if (do_push) sum_mem[wr_ptr_q] <= push_sum;
    end

    assign row_sum = row_valid ? sum_mem[rd_ptr_q] : '0;
`endif
endmodule

// File: doc/systolic_result_collector.md
# systolic_result_collector

Receive-side counterpart of the systolic array output stream. Consumes the serialized result words (`c_dout`, `c_dout_idx`, `out_valid`) emitted one element per cycle and reassembles them into complete N-element rows of C. Completed rows are buffered in a small row FIFO and handed to downstream logic over a valid/ready handshake, tagged with their row number within the tile. Sits between the array core and the result writeback/checker.

## Interface

- `DIN_WIDTH`, default 8: operand width; result element width is 2*DIN_WIDTH, signed.
- `N`, default 4: array dimension; elements per row and rows per tile; N >= 2.
- `DEPTH`, default 4: row FIFO depth in rows; power of two, >= 2.

- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `out_valid` input 1: result word present this cycle.
- `c_dout` input 2*DIN_WIDTH: signed result element.
- `c_dout_idx` input $clog2(N): column index of `c_dout`.
- `row_valid` output 1: FIFO head row available.
- `row_ready` input 1: downstream accepts head row.
- `row_data` output N*2*DIN_WIDTH: head row; element k at bits [k*2*DIN_WIDTH +: 2*DIN_WIDTH].
- `row_tag` output $clog2(N): row number of head row within tile.
- `fifo_level` output $clog2(DEPTH)+1: rows currently stored.
- `seq_err` output 1: sticky; index out of sequence seen.
- `ovf_err` output 1: sticky; completed row dropped, FIFO full.
- `err_clr` input 1: clears both sticky flags.

## Operation

- No backpressure on input; a word with `out_valid`=1 is always consumed.
- Internal: row assembly buffer (N elements), `exp_idx` counter, `tag_cnt` counter, FSM {COLLECT, RESYNC}.
- COLLECT: on `out_valid`, if `c_dout_idx`==`exp_idx`: store word at column `exp_idx`, increment `exp_idx`. When `exp_idx`==N-1 is stored, the row completes: push {buffer, `tag_cnt`}, `exp_idx`<=0, `tag_cnt` increments, wrapping N-1 -> 0.
- COLLECT, index mismatch: set `seq_err`, discard partial row. If mismatching idx is 0, treat it as the first word of a new row (store, `exp_idx`<=1), stay in COLLECT; otherwise go to RESYNC. `tag_cnt` unchanged.
- RESYNC: ignore words until `out_valid` with idx 0; store it, `exp_idx`<=1, go to COLLECT.
- Push when FIFO full and no pop in same cycle: row dropped, `ovf_err` set, `tag_cnt` still increments.
- Push and pop in same cycle: both take effect, including when full; level unchanged.
- Pop: `row_valid` && `row_ready`. `row_data`/`row_tag` stable while `row_valid`=1 and not popped.
- `err_clr` same cycle as a new error event: set wins.
- FIFO pointers wrap modulo DEPTH.

## Timing

- Reset: `row_valid`=0, `row_data`=0, `row_tag`=0, `fifo_level`=0, `seq_err`=0, `ovf_err`=0, FSM=COLLECT, `exp_idx`=0, `tag_cnt`=0, assembly buffer cleared.
- Latency: last word (idx N-1) sampled at edge t -> `row_valid`=1 and `fifo_level` updated after edge t (visible cycle t+1) if FIFO was empty.
- Throughput: one word per cycle sustained; one row per N cycles.
- Error flags assert in the cycle after the offending word's edge.
- Reset mid-row: partial row and all FIFO contents discarded immediately, asynchronously.

## Configuration

- `SYSTOLIC_COLLECT_ROWSUM_EN` defined: adds output `row_sum`, signed, width 2*DIN_WIDTH+$clog2(N), the sign-extended sum of the head row's N elements, accumulated during assembly and stored in the FIFO alongside the row; reset 0; discarded with the partial row on mismatch.
- Undefined: no `row_sum` port, no accumulator or FIFO storage for it.

## Test plan

- Reset then N=4 words idx 0..3 values 1,-2,3,-4 with `row_ready`=1 -> one row, `row_data` elements {1,-2,3,-4}, `row_tag`=0, `row_valid` one cycle after idx 3; `row_sum`=-2 with macro.
- 4 consecutive rows back to back, `row_ready`=1 -> tags 0,1,2,3, then fifth row tag 0; no errors.
- `row_ready`=0, 5 rows with DEPTH=4 -> `fifo_level`=4, fifth row dropped, `ovf_err`=1; drain yields tags 0..3 in order.
- Words idx 0,1,3 then 2,3 then 0,1,2,3 -> `seq_err`=1, RESYNC discards 2,3, exactly one row output with the last four values, tag 0.
- FIFO full, pop and completing push in same cycle -> level stays 4, no `ovf_err`, order preserved.
- `rst` asserted mid-row after idx 0,1 and with 2 rows queued -> outputs all zero immediately; next full row gets tag 0.
